// File: rtl/gpc_pkg.sv
// Shared definitions for the sequential population counter.
//   StIdle/StRun/StDone : FSM state encoding
//   clog2()             : ceil(log2(value)); returns 0 for value <= 1
package gpc_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/gpc3_2.sv
// 3:2 generalised parallel counter: counts the ones among three input bits.
//   in_i  [2:0] : bits to count
//   sum_o [1:0] : number of set bits (0..3)
// Built as a full adder: parity gives the LSB, majority gives the carry.
module gpc3_2 (
  input  logic [2:0] in_i,
  output logic [1:0] sum_o
);

  always_comb begin
    sum_o[0] = ^in_i;
    sum_o[1] = (in_i[0] & in_i[1]) | (in_i[0] & in_i[2]) | (in_i[1] & in_i[2]);
  end

endmodule

// File: rtl/gpc_popcount_seq.sv
// Sequential population counter: accepts one WIDTH-bit word, then folds it
// three bits per cycle through a single shared gpc3_2 into an accumulator.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : upstream word valid
//   in_ready  : high only in IDLE (and therefore throughout reset)
//   in_data   : word whose set bits are counted
//   out_valid : high only in DONE
//   out_ready : downstream accepts the result
//   out_count : population count of the accepted word, stable in DONE
// Latency: accept edge -> NCHUNK RUN cycles -> DONE.
module gpc_popcount_seq
  import gpc_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned NCHUNK = (WIDTH + 2) / 3;
  localparam int unsigned PAD_W  = 3 * NCHUNK;
  // Keep the chunk counter at least one bit wide for single-chunk builds.
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LastChunk = IDX_W'(NCHUNK - 1);

  logic [1:0]       state_q, state_d;
  logic [PAD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] chunk_q, chunk_d;
  logic [1:0]       chunk_sum;

  gpc3_2 u_gpc (
    .in_i  (shift_q[2:0]),
    .sum_o (chunk_sum)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    chunk_d = chunk_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Zero padding above WIDTH means the last chunk never over-counts.
          shift_d = PAD_W'(in_data);
          acc_d   = '0;
          chunk_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_q + CNT_W'(chunk_sum);
        shift_d = shift_q >> 3;
        chunk_d = chunk_q + IDX_W'(1);
        if (chunk_q == LastChunk) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      chunk_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      chunk_q <= chunk_d;
    end
  end

  // Decoded straight from state so reset drives in_ready high immediately.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_count = acc_q;
  end

endmodule
